ehgu_mod_fifo: RTL
==================

Name: ehgu_mod_fifo

Overview:
- Single-clock FIFO with valid/ready on both sides and a configurable depth that need not be a power of two.
- Read and write pointers wrap with modulo arithmetic from the team's basic utility package.
- Exports occupancy and a Gray-coded write pointer for status and monitoring logic.
- Sits directly downstream of datapath producers that use the basic package, and buffers DP_WIDTH-wide words to the next stage.

Parameters:
- DATA_WIDTH, DP_WIDTH (from ehgu_config_pkg), width of a stored word.
- DEPTH, 12, number of entries; legal range 2..2**DP_WIDTH-1, any integer.
- AF_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts.
- PTR_W, DP_WIDTH, pointer width; must hold DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pointers and count.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO accepts a word this cycle.
- in_data  in  DATA_WIDTH  write word.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the head word this cycle.
- out_data  out  DATA_WIDTH  head word.
- count  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  count >= AF_LEVEL.
- wr_ptr_gray  out  PTR_W  Gray code of the write pointer.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: in_ready=1, out_valid=0, almost_full=0 (when AF_LEVEL>0), wr_ptr_gray=0.
  - out_data=0; storage contents are not reset.
- Transfer rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH); it does not depend on out_ready, so there is no write-through when full.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], driven combinationally from storage. It is 0 when count==0 so the output never shows stale data.
- Latency: a word pushed in cycle N is visible on out_valid/out_data in cycle N+1. There is no same-cycle bypass when empty.
- Pointers:
  - On push, mem[wr_ptr] <= in_data and wr_ptr <= increment_modulo_unsigned(wr_ptr, DEPTH), so it wraps from DEPTH-1 to 0.
  - On pop, rd_ptr advances by the same rule.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - push & pop: unchanged.
  - count never exceeds DEPTH and never underflows.
- wr_ptr_gray is registered and equals bin2gray(wr_ptr) for the current wr_ptr. It is updated in the same edge as wr_ptr.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, both occur and count holds.
  - When count==DEPTH, only pop is possible.
  - When count==0, only push is possible.
- Flush:
  - Highest priority after reset. In the cycle flush=1, any push/pop is ignored.
  - Next edge: both pointers and count go to 0, and wr_ptr_gray goes to 0.
  - in_ready stays driven by the current count during the flush cycle. The producer must treat a flush-cycle word as dropped.
- Reset mid-operation:
  - Asynchronous assertion immediately forces the reset values above.
  - Deassertion is assumed synchronised upstream. The first push is accepted on the first edge after rst_n rises.
- Width rules:
  - The modulo argument is DEPTH, zero-extended to PTR_W+1.
  - The count arithmetic has no overflow path because of the full/empty gating above.

Decomposition:
- ehgu_fifo_pkg holds:
  - typedef ptr_t (logic [PTR_W-1:0]).
  - typedef cnt_t (logic [$clog2(DEPTH+1)-1:0]).
  - constant DEPTH_DEFAULT=12.
- Pointer wrap uses increment_modulo_unsigned, and the Gray output uses bin2gray, both from ehgu_basic_pkg.
- Sub-module ehgu_mod_ptr holds one modulo-wrapping pointer register with inputs en, clr and a DEPTH parameter. It is instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
- Reset then idle, DEPTH=12 → in_ready=1, out_valid=0, count=0, wr_ptr_gray=0, out_data=0.
- Push 12 words 0x01..0x0C with out_ready=0 →
  - count=12, in_ready=0, almost_full=1 from count 10.
  - A 13th push is not accepted and count stays 12.
- From full, raise out_ready with in_valid=1 →
  - Cycle 1: pop only, out_data=0x01, count=11.
  - Next cycle: push and pop together, count holds at 11.
- Wrap: 30 push/pop pairs with DEPTH=12 →
  - wr_ptr sequence ...,10,11,0,1...
  - wr_ptr_gray steps 0xE→0x0 at the wrap (Gray of 11, then Gray of 0).
  - Data order is preserved.
- Single push into empty in cycle N → out_valid=0 in cycle N and 1 in cycle N+1 with the pushed data.
- Flush and reset:
  - Flush with count=5 while pushing and popping → next cycle count=0, out_valid=0, wr_ptr_gray=0, and the flush-cycle word is absent.
  - Mid-stream rst_n pulse, asserted asynchronously between edges → outputs go to reset values before the next edge.

Source files
------------

// File: rtl/ehgu_basic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ehgu_basic_pkg
// Description : Small arithmetic helpers shared across the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package ehgu_basic_pkg;

    // Operands are 32 bits wide; callers zero-extend and cast the result back.
    function automatic logic [31:0] increment_modulo_unsigned(
        input logic [31:0] value,
        input logic [31:0] modulo
    );
        logic [31:0] w_inc;
        w_inc = value + 32'd1;
        return (w_inc >= modulo) ? 32'd0 : w_inc;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ehgu_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ehgu_config_pkg
// Description : Datapath-wide configuration constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ehgu_config_pkg;

    localparam int DP_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/ehgu_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ehgu_fifo_pkg
// Description : Shared types and defaults for the modulo-depth FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package ehgu_fifo_pkg;

    import ehgu_config_pkg::*;

    localparam int DEPTH_DEFAULT = 12;
    localparam int FIFO_PTR_W    = DP_WIDTH;

    typedef logic [FIFO_PTR_W-1:0]                ptr_t;
    typedef logic [$clog2(DEPTH_DEFAULT+1)-1:0]   cnt_t;

endpackage
`default_nettype wire

// File: rtl/ehgu_mod_ptr.sv
`default_nettype none
// ============================================================================
// Module      : ehgu_mod_ptr
// Description : Pointer register that wraps from DEPTH-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ehgu_mod_ptr
    import ehgu_basic_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W:0] c_MODULO = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= PTR_W'(increment_modulo_unsigned(32'(r_ptr), 32'(c_MODULO)));
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/ehgu_mod_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ehgu_mod_fifo
// Description : Single-clock valid/ready FIFO with arbitrary (non power of
//               two) depth, occupancy output and Gray-coded write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module ehgu_mod_fifo
    import ehgu_config_pkg::*;
    import ehgu_basic_pkg::*;
    import ehgu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DP_WIDTH,
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int PTR_W      = DP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic [PTR_W-1:0]           wr_ptr_gray
);

    localparam int                 c_CNT_W  = $clog2(DEPTH+1);
    localparam int                 c_IDX_W  = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [PTR_W:0]     c_MODULO = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      w_wr_ptr;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic [c_CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]      r_wr_gray;
    logic                  w_push;
    logic                  w_pop;

    // Flush swallows any handshake in its cycle.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    ehgu_mod_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_push),
        .clr   (flush),
        .ptr   (w_wr_ptr)
    );

    ehgu_mod_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_pop),
        .clr   (flush),
        .ptr   (w_rd_ptr)
    );

    assign w_wr_idx = c_IDX_W'(w_wr_ptr);
    assign w_rd_idx = c_IDX_W'(w_rd_ptr);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + c_ONE;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - c_ONE;
        end
    end

    // Tracks the Gray code of the pointer value loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_gray <= '0;
        end else if (flush) begin
            r_wr_gray <= '0;
        end else if (w_push) begin
            r_wr_gray <= PTR_W'(bin2gray(
                increment_modulo_unsigned(32'(w_wr_ptr), 32'(c_MODULO))));
        end
    end

    assign out_data    = out_valid ? r_mem[w_rd_idx] : '0;
    assign count       = r_count;
    assign almost_full = (int'(r_count) >= AF_LEVEL);
    assign wr_ptr_gray = r_wr_gray;

endmodule
`default_nettype wire
